// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage next-PC sequencer.
// Holds the FSM encoding, BHT counter values and 2-bit saturating arithmetic.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
      return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/branch_hist_table.sv
// 2-bit saturating branch history table: async read of the taken bit,
// synchronous update from EX-stage resolution.
module branch_hist_table
   import pc_seq_pkg::*;
#(
   parameter int         IDX_W    = 6,
   parameter logic [1:0] CNT_INIT = CNT_WNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int N = 1 << IDX_W;

   logic [1:0] cnt_q [N];
   logic [1:0] cnt_d [N];

   // Reads see the pre-update value; a same-index update shows up next cycle.
   assign rd_taken = cnt_q[rd_idx][1];

   always_comb begin
      cnt_d = cnt_q;
      if (upd_en) begin
         cnt_d[upd_idx] = upd_taken ? sat_inc(cnt_q[upd_idx]) : sat_dec(cnt_q[upd_idx]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: PC register, BHT-based prediction,
// mispredict redirect/flush and the BOOT/RUN/HALT sequencing.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          BHT_IDX_W = 6,
   parameter logic [1:0]  CNT_INIT  = 2'b01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        if_is_branch,
   input  logic [31:0] if_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        pred_taken,
   output logic        flush,
   output logic [31:0] br_cnt,
   output logic [31:0] mis_cnt
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;
   logic        bht_taken;
   logic        mispredict;
   logic [31:0] correct_pc;

   branch_hist_table #(
      .IDX_W    (BHT_IDX_W),
      .CNT_INIT (CNT_INIT)
   ) u_bht (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (pc_q[BHT_IDX_W+1:2]),
      .rd_taken  (bht_taken),
      .upd_en    (ex_valid),
      .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
      .upd_taken (ex_taken)
   );

   // Nothing in flight during BOOT can be a genuine branch, so redirects only count in RUN/HALT.
   assign mispredict = ex_valid & (ex_taken != ex_pred_taken) & (state_q != BOOT);
   assign correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;

   assign pc         = pc_q;
   assign pc_valid   = (state_q == RUN);
   assign pred_taken = (state_q == RUN) & if_is_branch & bht_taken;
   assign flush      = mispredict & reset;
   assign br_cnt     = br_cnt_q;
   assign mis_cnt    = mis_cnt_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (mispredict) begin
               pc_d = correct_pc;
            end else if (halt_req) begin
               state_d = HALT;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (pred_taken) begin
               pc_d = if_target;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         HALT: begin
            if (mispredict) begin
               pc_d = correct_pc;
            end else if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (ex_valid && (br_cnt_q != 32'hFFFF_FFFF)) begin
         br_cnt_d = br_cnt_q + 32'd1;
      end
      if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
         mis_cnt_d = mis_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VEC;
         br_cnt_q  <= 32'd0;
         mis_cnt_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written multi-cycle
// sequences for training, redirects, wrap-around, halt/resume and mid-run reset.
module tb_pc_sequencer;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        exv;
      logic [31:0] expc;
      logic        ext;
      logic [31:0] extgt;
      logic        expred;
      logic        halt;
      logic        resume;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_pred;
      logic        exp_flush;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        if_is_branch;
   logic [31:0] if_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pred_taken;
   logic        flush;
   logic [31:0] br_cnt;
   logic [31:0] mis_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   vec_t vecs [12];
   vec_t v;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .if_is_branch  (if_is_branch),
      .if_target     (if_target),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc            (pc),
      .pc_valid      (pc_valid),
      .pred_taken    (pred_taken),
      .flush         (flush),
      .br_cnt        (br_cnt),
      .mis_cnt       (mis_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   function automatic vec_t idle(input logic [31:0] exp_pc, input logic exp_valid);
      vec_t r;
      r = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
            exp_pc, exp_valid, 1'b0, 1'b0};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t s);
      @(negedge clk);
      reset         = s.rst_n;
      stall         = s.stall;
      if_is_branch  = s.br;
      if_target     = s.tgt;
      ex_valid      = s.exv;
      ex_pc         = s.expc;
      ex_taken      = s.ext;
      ex_target     = s.extgt;
      ex_pred_taken = s.expred;
      halt_req      = s.halt;
      resume        = s.resume;
      #1;
   endtask

   task automatic checkOutput(input vec_t s, input string tag);
      check({tag, ".pc"},         pc,                 s.exp_pc);
      check({tag, ".pc_valid"},   {31'd0, pc_valid},   {31'd0, s.exp_valid});
      check({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, s.exp_pred});
      check({tag, ".flush"},      {31'd0, flush},      {31'd0, s.exp_flush});
   endtask

   task automatic run(input vec_t s, input string tag);
      applyStimulus(s);
      checkOutput(s, tag);
   endtask

   task automatic checkCounts(input string tag, input logic [31:0] br, input logic [31:0] mis);
      check({tag, ".br_cnt"},  br_cnt,  br);
      check({tag, ".mis_cnt"}, mis_cnt, mis);
   endtask

   initial begin
      // rst_n stall br tgt exv expc ext extgt expred halt resume | pc valid pred flush
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 1'b0, 1'b0};

      reset = 1'b0; stall = 1'b0; if_is_branch = 1'b0; if_target = 32'h0;
      ex_valid = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0; ex_target = 32'h0;
      ex_pred_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
      @(posedge clk);

      for (int i = 0; i < 12; i++) begin
         run(vecs[i], $sformatf("vec%0d", i));
      end
      checkCounts("after_boot", 32'd0, 32'd0);

      // Train idx(0x20) to strongly taken while holding pc at 0x1C.
      for (int i = 0; i < 3; i++) begin
         v = idle(32'h1C, 1'b1);
         v.stall = 1'b1; v.exv = 1'b1; v.expc = 32'h20; v.ext = 1'b1; v.extgt = 32'h80; v.expred = 1'b1;
         run(v, $sformatf("train%0d", i));
      end
      run(idle(32'h1C, 1'b1), "train_release");

      // Predicted taken, with a same-cycle not-taken update that must not affect this read.
      v = idle(32'h20, 1'b1);
      v.br = 1'b1; v.tgt = 32'h80; v.exp_pred = 1'b1;
      v.exv = 1'b1; v.expc = 32'h20; v.ext = 1'b0; v.expred = 1'b0;
      run(v, "pred_st");

      v = idle(32'h80, 1'b1);
      v.exv = 1'b1; v.expc = 32'h0; v.ext = 1'b1; v.extgt = 32'h20; v.expred = 1'b0; v.exp_flush = 1'b1;
      run(v, "redir_to_20");

      v = idle(32'h20, 1'b1);
      v.br = 1'b1; v.tgt = 32'h80; v.exp_pred = 1'b1;
      run(v, "pred_wt");

      // Mispredict coinciding with stall: redirect wins.
      v = idle(32'h80, 1'b1);
      v.stall = 1'b1; v.exv = 1'b1; v.expc = 32'h40; v.ext = 1'b1; v.extgt = 32'h100; v.expred = 1'b0;
      v.exp_flush = 1'b1;
      run(v, "mis_vs_stall");
      checkCounts("pre_mis_vs_stall", 32'd5, 32'd1);

      // Not-taken mispredict at the top of the address space wraps to 0.
      v = idle(32'h100, 1'b1);
      v.exv = 1'b1; v.expc = 32'hFFFF_FFFC; v.ext = 1'b0; v.expred = 1'b1; v.exp_flush = 1'b1;
      run(v, "wrap_mis");
      checkCounts("post_mis_vs_stall", 32'd6, 32'd2);

      v = idle(32'h0, 1'b1);
      v.exv = 1'b1; v.expc = 32'h2C; v.ext = 1'b0; v.expred = 1'b1; v.exp_flush = 1'b1;
      run(v, "redir_to_30");
      checkCounts("post_wrap", 32'd7, 32'd3);

      v = idle(32'h30, 1'b1);
      v.halt = 1'b1;
      run(v, "halt_req");
      checkCounts("pre_halt", 32'd8, 32'd4);

      for (int i = 0; i < 5; i++) begin
         v = idle(32'h30, 1'b0);
         v.br = 1'b1; v.tgt = 32'h500;
         run(v, $sformatf("halted%0d", i));
      end
      v = idle(32'h30, 1'b0);
      v.resume = 1'b1;
      run(v, "resume");
      run(idle(32'h30, 1'b1), "first_fetch");

      // halt_req in the same cycle as a mispredict: redirect, stay in RUN.
      v = idle(32'h34, 1'b1);
      v.halt = 1'b1; v.exv = 1'b1; v.expc = 32'h50; v.ext = 1'b1; v.extgt = 32'h60; v.expred = 1'b0;
      v.exp_flush = 1'b1;
      run(v, "halt_vs_mis");
      run(idle(32'h60, 1'b1), "after_halt_vs_mis");
      checkCounts("after_halt_vs_mis", 32'd9, 32'd5);

      v = idle(32'h64, 1'b1);
      v.halt = 1'b1;
      run(v, "halt2_req");

      // A mispredict while halted moves the frozen pc but keeps HALT.
      v = idle(32'h64, 1'b0);
      v.exv = 1'b1; v.expc = 32'h70; v.ext = 1'b0; v.expred = 1'b1; v.exp_flush = 1'b1;
      run(v, "halt_mis");
      v = idle(32'h74, 1'b0);
      v.resume = 1'b1;
      run(v, "halt2_resume");
      v = idle(32'h74, 1'b1);
      v.resume = 1'b1;
      run(v, "resume_in_run");
      run(idle(32'h78, 1'b1), "after_resume_in_run");
      checkCounts("after_halt2", 32'd10, 32'd6);

      // Mid-run reset overrides mispredict and halt_req.
      v = idle(32'h7C, 1'b1);
      v.rst_n = 1'b0; v.halt = 1'b1; v.exv = 1'b1; v.expc = 32'h40; v.ext = 1'b1; v.extgt = 32'h100;
      v.expred = 1'b0; v.exp_flush = 1'b0;
      run(v, "mid_reset");
      run(idle(32'h0, 1'b0), "post_reset_boot");
      checkCounts("post_reset", 32'd0, 32'd0);
      run(idle(32'h0, 1'b1), "post_reset_run");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
